// File: rtl/multi_input_gate_pipe.sv
// multi_input_gate_pipe: two-stage valid/ready pipeline computing a selectable N-input gate with popcount and a saturating delivery counter
module multi_input_gate_pipe #(
  parameter int N_IN = 3,
  parameter int CNT_W = 16,
  localparam int PW = $clog2(N_IN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IN-1:0]  i_data,
  input  logic [2:0]       i_code,
  input  logic [PW-1:0]    i_thresh,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_f,
  output logic [PW-1:0]    o_pop,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count
);
  logic            s1_valid;
  logic [N_IN-1:0] s1_data;
  logic [2:0]      s1_code;
  logic [PW-1:0]   s1_thresh;
  logic [PW-1:0]   pop;
  logic            f;
  logic            out_xfer;
  logic            s2_load;
  assign out_xfer = o_valid && i_ready;
  assign s2_load  = s1_valid && (!o_valid || i_ready);
  assign o_ready  = !s1_valid || s2_load;
  always_comb begin
    pop = '0;
    for (int k = 0; k < N_IN; k++) pop = pop + PW'(s1_data[k]);
    f = s1_code == 3'd0 ? &s1_data :
        s1_code == 3'd1 ? |s1_data :
        s1_code == 3'd2 ? ^s1_data :
        s1_code == 3'd3 ? ~&s1_data :
        s1_code == 3'd4 ? ~|s1_data :
        s1_code == 3'd5 ? ~^s1_data :
        s1_code == 3'd6 ? pop > PW'(N_IN / 2) :
                          pop >= s1_thresh;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_code   <= '0;
      s1_thresh <= '0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_data   <= i_data;
        s1_code   <= i_code;
        s1_thresh <= i_thresh;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_f     <= 1'b0;
      o_pop   <= '0;
    end else if (s2_load) begin
      o_valid <= 1'b1;
      o_f     <= f;
      o_pop   <= pop;
    end else if (out_xfer) begin
      o_valid <= 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) o_count <= '0;
    else if (out_xfer && o_count != {CNT_W{1'b1}}) o_count <= o_count + 1'b1;
  end
endmodule

// File: tb/tb_multi_input_gate_pipe.sv
// tb_multi_input_gate_pipe: directed and scoreboard checks of the gate pipeline at N_IN=3, CNT_W=4 and N_IN=8
module tb_multi_input_gate_pipe;
  logic        clk = 0;
  logic        rst = 1;
  logic        valid = 0, ready = 0;
  logic [2:0]  data = 0, code = 0;
  logic [1:0]  thresh = 0;
  logic        o_ready, o_f, o_valid;
  logic [1:0]  o_pop;
  logic [15:0] o_count;
  logic        c_ready, c_f, c_valid;
  logic [1:0]  c_pop;
  logic [3:0]  c_count;
  logic        w_valid = 0, w_ready = 0;
  logic [7:0]  w_data = 0;
  logic [2:0]  w_code = 0;
  logic [3:0]  w_thresh = 0;
  logic        wo_ready, wo_f, wo_valid;
  logic [3:0]  wo_pop;
  logic [15:0] wo_count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  multi_input_gate_pipe #(.N_IN(3), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_code(code), .i_thresh(thresh),
    .i_valid(valid), .o_ready(o_ready), .o_f(o_f), .o_pop(o_pop), .o_valid(o_valid),
    .i_ready(ready), .o_count(o_count));
  multi_input_gate_pipe #(.N_IN(3), .CNT_W(4)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_code(code), .i_thresh(thresh),
    .i_valid(valid), .o_ready(c_ready), .o_f(c_f), .o_pop(c_pop), .o_valid(c_valid),
    .i_ready(ready), .o_count(c_count));
  multi_input_gate_pipe #(.N_IN(8), .CNT_W(16)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_data(w_data), .i_code(w_code), .i_thresh(w_thresh),
    .i_valid(w_valid), .o_ready(wo_ready), .o_f(wo_f), .o_pop(wo_pop), .o_valid(wo_valid),
    .i_ready(w_ready), .o_count(wo_count));
  function automatic logic exp_f(input logic [7:0] d, input int n, input logic [2:0] c, input int t);
    int p;
    p = $countones(d);
    case (c)
      3'd0: return p == n;
      3'd1: return p != 0;
      3'd2: return p % 2 == 1;
      3'd3: return p != n;
      3'd4: return p == 0;
      3'd5: return p % 2 == 0;
      3'd6: return p > n / 2;
      default: return p >= t;
    endcase
  endfunction
  task test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (o_valid !== 0 || o_f !== 0 || o_pop !== 0 || o_count !== 0 || o_ready !== 1) begin
      failures++;
      $display("FAIL reset: valid=%b f=%b pop=%0d count=%0d ready=%b, want 0 0 0 0 1", o_valid, o_f, o_pop, o_count, o_ready);
    end
  endtask
  task test_sweep;
    int k, ep;
    logic ef;
    logic rdy_ok;
    rdy_ok = 1;
    ready = 1;
    thresh = 2;
    for (int j = 0; j < 66; j++) begin
      @(posedge clk); #1;
      valid = j < 64;
      data = 3'(j / 8);
      code = 3'(j % 8);
      @(negedge clk);
      if (o_ready !== 1) rdy_ok = 0;
      if (j >= 2) begin
        k = j - 2;
        ef = exp_f(8'(k / 8), 3, 3'(k % 8), 2);
        ep = $countones(k / 8);
        checks++;
        if (o_valid !== 1 || o_f !== ef || o_pop !== 2'(ep)) begin
          failures++;
          $display("FAIL sweep data=%0d code=%0d: valid=%b f=%b pop=%0d, want 1 %b %0d", k / 8, k % 8, o_valid, o_f, o_pop, ef, ep);
        end
      end
    end
    checks++;
    if (!rdy_ok) begin
      failures++;
      $display("FAIL sweep_ready: o_ready dropped=1, want 0");
    end
    valid = 0;
  endtask
  task test_directed;
    logic [2:0] dd [7] = '{3'b011, 3'b001, 3'b111, 3'b111, 3'b000, 3'b011, 3'b101};
    logic [2:0] dc [7] = '{3'b110, 3'b010, 3'b111, 3'b111, 3'b111, 3'b111, 3'b011};
    logic [1:0] dt [7] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
    logic       df [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] dp [7] = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd2};
    ready = 1;
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      valid = j < 7;
      if (j < 7) begin data = dd[j]; code = dc[j]; thresh = dt[j]; end
      @(negedge clk);
      if (j >= 2) begin
        checks++;
        if (o_valid !== 1 || o_f !== df[j-2] || o_pop !== dp[j-2]) begin
          failures++;
          $display("FAIL directed %0d: valid=%b f=%b pop=%0d, want 1 %b %0d", j - 2, o_valid, o_f, o_pop, df[j-2], dp[j-2]);
        end
      end
    end
    valid = 0;
  endtask
  task test_back_to_back;
    logic [2:0] bd [5] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110};
    logic [2:0] bc [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic       bf [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] bp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    @(posedge clk); #1;
    rst = 1; valid = 0; ready = 0;
    @(posedge clk); #1;
    rst = 0;
    while (got < 5 && cyc < 40) begin
      @(posedge clk); #1;
      ready = cyc >= 6;
      valid = sent < 5;
      if (sent < 5) begin data = bd[sent]; code = bc[sent]; end
      @(negedge clk);
      if (cyc == 5) begin
        checks++;
        if (sent !== 2 || o_ready !== 0) begin
          failures++;
          $display("FAIL stall_accept: accepted=%0d ready=%b, want 2 0", sent, o_ready);
        end
      end
      if (o_valid && ready) begin
        checks++;
        if (o_f !== bf[got] || o_pop !== bp[got]) begin
          failures++;
          $display("FAIL b2b_order %0d: f=%b pop=%0d, want %b %0d", got, o_f, o_pop, bf[got], bp[got]);
        end
        got++;
      end
      if (valid && o_ready) sent++;
      cyc++;
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL b2b_timeout: delivered=%0d, want 5", got);
    end
    @(posedge clk); #1;
    valid = 0; ready = 0;
    @(negedge clk);
    checks++;
    if (o_count !== 5 || o_valid !== 0) begin
      failures++;
      $display("FAIL b2b_count: count=%0d valid=%b, want 5 0", o_count, o_valid);
    end
  endtask
  task test_reset_flush;
    logic stale;
    stale = 0;
    @(posedge clk); #1;
    ready = 0; valid = 1; data = 3'b111; code = 3'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_valid !== 1 || o_ready !== 0) begin
      failures++;
      $display("FAIL flush_buffered: valid=%b ready=%b, want 1 0", o_valid, o_ready);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; valid = 0; ready = 1;
    @(negedge clk);
    checks++;
    if (o_valid !== 0 || o_count !== 0 || o_ready !== 1) begin
      failures++;
      $display("FAIL flush_reset: valid=%b count=%0d ready=%b, want 0 0 1", o_valid, o_count, o_ready);
    end
    repeat (6) begin
      @(negedge clk);
      if (o_valid !== 0) stale = 1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL flush_stale: stale result seen=1, want 0");
    end
  endtask
  task test_saturate;
    ready = 1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      valid = 1; data = 3'(j); code = 3'(j);
    end
    @(posedge clk); #1;
    valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (c_count !== 15 || o_count !== 20) begin
      failures++;
      $display("FAIL saturate: count4=%0d count16=%0d, want 15 20", c_count, o_count);
    end
    @(posedge clk); #1;
    valid = 1;
    @(posedge clk); #1;
    valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (c_count !== 15 || o_count !== 21) begin
      failures++;
      $display("FAIL saturate_hold: count4=%0d count16=%0d, want 15 21", c_count, o_count);
    end
  endtask
  task test_wide;
    logic [4:0] q [$];
    logic [4:0] e;
    int acc, del;
    acc = 0; del = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        w_valid = 1; w_data = 8'hff; w_code = 3'd7; w_thresh = 4'd9;
      end else begin
        w_valid = cyc < 370 && $urandom_range(0, 3) != 0;
        w_data = 8'($urandom);
        w_code = 3'($urandom);
        w_thresh = 4'($urandom);
      end
      w_ready = cyc >= 380 || $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (wo_valid && w_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL wide_spurious: f=%b pop=%0d, want no result", wo_f, wo_pop);
        end else begin
          e = q.pop_front();
          if ({wo_f, wo_pop} !== e) begin
            failures++;
            $display("FAIL wide_result %0d: f=%b pop=%0d, want %b %0d", del, wo_f, wo_pop, e[4], e[3:0]);
          end
        end
        del++;
      end
      if (w_valid && wo_ready) begin
        q.push_back({exp_f(w_data, 8, w_code, int'(w_thresh)), 4'($countones(w_data))});
        acc++;
      end
    end
    @(posedge clk); #1;
    w_valid = 0;
    @(negedge clk);
    checks++;
    if (q.size() != 0 || del != acc || wo_count !== 16'(del)) begin
      failures++;
      $display("FAIL wide_drain: pending=%0d delivered=%0d count=%0d, want 0 %0d %0d", q.size(), del, wo_count, acc, acc);
    end
  endtask
  initial begin
    test_reset;
    test_sweep;
    test_directed;
    test_back_to_back;
    test_reset_flush;
    test_saturate;
    test_wide;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
